// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE-style core: sequencer state encoding,
// instruction field codes and the control bundle passed from the phase
// decoder to the sequencer registers. The ALU and instruction decoder also
// import this package.
package simple_pkg;

  // Sequencer state encoding. It is also visible on the phase output.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_MEM  = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd7;

  // Major instruction class, ir[15:14]
  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_ST  = 2'b01;
  localparam logic [1:0] OP1_BR  = 2'b10;
  localparam logic [1:0] OP1_ALU = 2'b11;

  // Sub-class for the BR group, ir[13:11]
  localparam logic [2:0] OP2_LI  = 3'b000;
  localparam logic [2:0] OP2_B   = 3'b100;
  localparam logic [2:0] OP2_BCC = 3'b111;

  // ALU group opcodes that change sequencing, ir[7:4]
  localparam logic [3:0] ALU_CMP = 4'd5;
  localparam logic [3:0] ALU_OUT = 4'd13;
  localparam logic [3:0] ALU_HLT = 4'd15;

  // Per-cycle control produced by phase_decode. The update enables are
  // already gated by stall, so the register block applies them directly.
  typedef struct packed {
    logic [2:0] next_state;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load_alu;
    logic       flags_load;
  } seq_ctrl_t;

endpackage

// File: rtl/phase_sequencer_if.sv
// Signal bundle between the phase sequencer and the rest of the core
// (memory, register file, ALU).
//
// Handshake: there is no valid/ready pair. The memory side applies
// backpressure through stall. While stall is high the sequencer holds all of
// its state, keeps mem_re asserted in IF/MEM so the read completes, and
// forces mem_we/reg_we low. A phase completes on the first rising edge that
// sees stall low.
interface phase_sequencer_if;

  // Environment to sequencer
  logic        start;
  logic        stall;
  logic [15:0] mem_rdata;
  logic [15:0] alu_out;
  logic        alu_s;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;
  logic        alu_hlt;

  // Sequencer to environment
  logic [15:0] pc;
  logic [15:0] ir;
  logic [2:0]  phase;
  logic        flag_s;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        mem_re;
  logic        mem_we;
  logic        reg_we;
  logic        halted;
  logic        busy;

  // Sequencer side
  modport master (
    input  start, stall, mem_rdata, alu_out,
    input  alu_s, alu_z, alu_c, alu_v, alu_hlt,
    output pc, ir, phase,
    output flag_s, flag_z, flag_c, flag_v,
    output mem_re, mem_we, reg_we, halted, busy
  );

  // Memory / ALU / register-file side
  modport slave (
    output start, stall, mem_rdata, alu_out,
    output alu_s, alu_z, alu_c, alu_v, alu_hlt,
    input  pc, ir, phase,
    input  flag_s, flag_z, flag_c, flag_v,
    input  mem_re, mem_we, reg_we, halted, busy
  );

endinterface

// File: rtl/phase_decode.sv
// Combinational next-state and strobe decoder for the phase sequencer.
// Maps the current state, the decoded instruction fields, stall and the few
// external events (start, alu_hlt) onto the next state, the strobes and the
// register update enables. It holds no state of its own.
module phase_decode
  import simple_pkg::*;
(
  input  logic [2:0] state,
  input  logic [1:0] op1,
  input  logic [2:0] op2,
  input  logic [3:0] opcode,
  input  logic       stall,
  input  logic       start,
  input  logic       alu_hlt,
  output seq_ctrl_t  ctrl
);

  logic halt_req;
  logic br_jump;
  logic ex_to_mem;
  logic ex_to_wb;

  // Instruction classification used by the EX phase
  always_comb begin
    halt_req  = ((op1 == OP1_ALU) && (opcode == ALU_HLT)) || alu_hlt;
    br_jump   = (op1 == OP1_BR) && ((op2 == OP2_B) || (op2 == OP2_BCC));
    ex_to_mem = (op1 == OP1_LD) || (op1 == OP1_ST);
    ex_to_wb  = ((op1 == OP1_ALU) && (opcode != ALU_CMP) && (opcode != ALU_OUT))
             || ((op1 == OP1_BR) && (op2 == OP2_LI));
  end

  // Per-state control, then stall freezes everything except mem_re
  always_comb begin
    ctrl            = '0;
    ctrl.next_state = state;

    case (state)
      ST_IDLE: begin
        if (start) ctrl.next_state = ST_IF;
      end

      ST_IF: begin
        ctrl.mem_re     = 1'b1;
        ctrl.ir_load    = 1'b1;
        ctrl.pc_inc     = 1'b1;
        ctrl.next_state = ST_ID;
      end

      ST_ID: begin
        ctrl.next_state = ST_EX;
      end

      ST_EX: begin
        if (halt_req) begin
          // Halting instructions leave flags and pc untouched
          ctrl.next_state = ST_HALT;
        end else begin
          ctrl.flags_load  = (op1 == OP1_ALU);
          // The ALU already resolved the condition; alu_out is pc+1 if untaken
          ctrl.pc_load_alu = br_jump;
          if (ex_to_mem)     ctrl.next_state = ST_MEM;
          else if (ex_to_wb) ctrl.next_state = ST_WB;
          else               ctrl.next_state = ST_IF;
        end
      end

      ST_MEM: begin
        if (op1 == OP1_LD) begin
          ctrl.mem_re     = 1'b1;
          ctrl.next_state = ST_WB;
        end else if (op1 == OP1_ST) begin
          ctrl.mem_we     = 1'b1;
          ctrl.next_state = ST_IF;
        end else begin
          ctrl.next_state = ST_IF;
        end
      end

      ST_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.next_state = ST_IF;
      end

      ST_HALT: begin
        ctrl.next_state = ST_HALT;
      end

      // Unused encoding 6 recovers to IDLE
      default: begin
        ctrl.next_state = ST_IDLE;
      end
    endcase

    // Memory not ready: hold every register and suppress write strobes.
    // mem_re is left alone so an in-flight read stays requested.
    if (stall && (state != 3'd6)) begin
      ctrl.next_state  = state;
      ctrl.mem_we      = 1'b0;
      ctrl.reg_we      = 1'b0;
      ctrl.ir_load     = 1'b0;
      ctrl.pc_inc      = 1'b0;
      ctrl.pc_load_alu = 1'b0;
      ctrl.flags_load  = 1'b0;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle control unit of the SIMPLE-style core. It steps every
// instruction through IF/ID/EX/MEM/WB, owns PC, IR and the S/Z/C/V flag
// register, and parks in HALT when the ALU reports a halt. All sequencing
// decisions are made in phase_decode; this module only holds the registers.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  phase_sequencer_if.master   bus
);

  logic [2:0]  state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [3:0]  flags_q;  // {S, Z, C, V}
  seq_ctrl_t   ctrl;

  phase_decode u_decode (
    .state   (state_q),
    .op1     (ir_q[15:14]),
    .op2     (ir_q[13:11]),
    .opcode  (ir_q[7:4]),
    .stall   (bus.stall),
    .start   (bus.start),
    .alu_hlt (bus.alu_hlt),
    .ctrl    (ctrl)
  );

  // State, PC, IR and flag registers; reset wins over every other update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      flags_q <= 4'b0000;
    end else begin
      state_q <= ctrl.next_state;
      if (ctrl.ir_load) ir_q <= bus.mem_rdata;
      if (ctrl.pc_load_alu)  pc_q <= bus.alu_out;
      else if (ctrl.pc_inc)  pc_q <= pc_q + 16'd1;
      if (ctrl.flags_load)
        flags_q <= {bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v};
    end
  end

  // Outputs: register copies, decoded strobes and state summaries
  always_comb begin
    bus.pc     = pc_q;
    bus.ir     = ir_q;
    bus.phase  = state_q;
    bus.flag_s = flags_q[3];
    bus.flag_z = flags_q[2];
    bus.flag_c = flags_q[1];
    bus.flag_v = flags_q[0];
    bus.mem_re = ctrl.mem_re;
    bus.mem_we = ctrl.mem_we;
    bus.reg_we = ctrl.reg_we;
    bus.halted = (state_q == ST_HALT);
    bus.busy   = (state_q >= ST_IF) && (state_q <= ST_WB);
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed testbench for phase_sequencer. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point, away from the edge.
module tb_phase_sequencer;
  import simple_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_sequencer_if bus();

  phase_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ph();
    return {13'd0, bus.phase};
  endfunction

  // {mem_re, mem_we, reg_we}
  function automatic logic [15:0] stb();
    return {13'd0, bus.mem_re, bus.mem_we, bus.reg_we};
  endfunction

  // {S, Z, C, V}
  function automatic logic [15:0] flg();
    return {12'd0, bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  function automatic logic [15:0] hb();
    return {14'd0, bus.halted, bus.busy};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [15:0] out, input logic [3:0] f, input logic h);
    bus.alu_out = out;
    {bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v} = f;
    bus.alu_hlt = h;
  endtask

  // Walks the expected phase trace, one entry per cycle. With no_we set,
  // mem_we and reg_we must stay low on every visited cycle.
  task automatic drain_phases(input string tag, input logic no_we);
    while (exp_q.size() > 0) begin
      check(tag, ph(), exp_q.pop_front());
      if (no_we) check({tag, "_we"}, {14'd0, bus.mem_we, bus.reg_we}, 16'd0);
      if (exp_q.size() > 0) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed vectors ----------------
  initial begin
    bus.start = 1'b0; bus.stall = 1'b0; bus.mem_rdata = 16'h0000;
    set_alu(16'h0000, 4'b0000, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_phase", ph(), 16'd0);
    check("rst_pc", bus.pc, 16'h0000);
    check("rst_ir", bus.ir, 16'h0000);
    check("rst_flags", flg(), 16'h0000);
    check("rst_strobes", stb(), 16'h0000);
    check("rst_halt_busy", hb(), 16'h0000);
    tick();
    check("idle_hold", ph(), 16'd0);

    // ADD: IF, ID, EX, WB; flags loaded in EX
    bus.mem_rdata = 16'hC000;
    set_alu(16'h0000, 4'b0010, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("add_if_phase", ph(), 16'd1);
    check("add_if_strobes", stb(), 16'b100);
    check("add_if_busy", hb(), 16'b01);
    tick();
    check("add_id_phase", ph(), 16'd2);
    check("add_id_pc", bus.pc, 16'h0001);
    check("add_id_ir", bus.ir, 16'hC000);
    check("add_id_strobes", stb(), 16'b000);
    tick();
    check("add_ex_phase", ph(), 16'd3);
    check("add_ex_strobes", stb(), 16'b000);
    tick();
    check("add_wb_phase", ph(), 16'd5);
    check("add_wb_strobes", stb(), 16'b001);
    check("add_flags", flg(), 16'b0010);
    tick();
    check("add_next_if", ph(), 16'd1);
    check("add_next_strobes", stb(), 16'b100);

    // CMP: 3 cycles, no writeback, Z set
    bus.mem_rdata = 16'hC050;
    set_alu(16'h0000, 4'b0100, 1'b0);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd1};
    drain_phases("cmp_phase", 1'b1);
    check("cmp_flags", flg(), 16'b0100);
    check("cmp_pc", bus.pc, 16'h0002);

    // BCC taken to 0040; ALU flags must not be loaded
    bus.mem_rdata = 16'hB800;
    set_alu(16'h0040, 4'b1111, 1'b0);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd1};
    drain_phases("bcc_phase", 1'b1);
    check("bcc_pc", bus.pc, 16'h0040);
    check("bcc_flags", flg(), 16'b0100);
    check("bcc_ir", bus.ir, 16'hB800);

    // LD with a 3-cycle stall in MEM: 8 cycles total
    bus.mem_rdata = 16'h0000;
    check("ld_if_strobes", stb(), 16'b100);
    tick();
    check("ld_id_pc", bus.pc, 16'h0041);
    tick();
    check("ld_ex_phase", ph(), 16'd3);
    tick();
    check("ld_mem_phase", ph(), 16'd4);
    check("ld_mem_strobes", stb(), 16'b100);
    bus.stall = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_stall_phase", ph(), 16'd4);
      check("ld_stall_strobes", stb(), 16'b100);
      check("ld_stall_pc", bus.pc, 16'h0041);
      check("ld_stall_ir", bus.ir, 16'h0000);
    end
    bus.stall = 1'b0;
    tick();
    check("ld_wb_phase", ph(), 16'd5);
    check("ld_wb_strobes", stb(), 16'b001);
    tick();
    check("ld_done_phase", ph(), 16'd1);
    check("ld_flags", flg(), 16'b0100);

    // ST with stall in MEM: mem_we suppressed while stalled
    bus.mem_rdata = 16'h4000;
    tick();
    check("st_id_pc", bus.pc, 16'h0042);
    tick();
    tick();
    check("st_mem_phase", ph(), 16'd4);
    check("st_mem_strobes", stb(), 16'b010);
    bus.stall = 1'b1;
    #1;
    check("st_stall_strobes", stb(), 16'b000);
    tick();
    check("st_stall_phase", ph(), 16'd4);
    check("st_stall_strobes2", stb(), 16'b000);
    bus.stall = 1'b0;
    #1;
    check("st_release_strobes", stb(), 16'b010);
    tick();
    check("st_done_phase", ph(), 16'd1);

    // LI: IF, ID, EX, WB
    bus.mem_rdata = 16'h8000;
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd1};
    drain_phases("li_phase", 1'b0);
    check("li_pc", bus.pc, 16'h0043);

    // B to FFFF, then ADD from FFFF wraps pc to 0000
    bus.mem_rdata = 16'hA000;
    set_alu(16'hFFFF, 4'b0000, 1'b0);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd1};
    drain_phases("b_phase", 1'b1);
    check("b_pc", bus.pc, 16'hFFFF);
    bus.mem_rdata = 16'hC000;
    set_alu(16'h0000, 4'b1111, 1'b0);
    tick();
    check("wrap_pc", bus.pc, 16'h0000);
    tick(); tick(); tick();
    check("wrap_flags", flg(), 16'b1111);

    // HLT: halts after EX, flags untouched, start ignored
    bus.mem_rdata = 16'hC0F0;
    set_alu(16'h0000, 4'b0000, 1'b0);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd7};
    drain_phases("hlt_phase", 1'b1);
    check("hlt_halt_busy", hb(), 16'b10);
    check("hlt_flags", flg(), 16'b1111);
    check("hlt_pc", bus.pc, 16'h0001);
    bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    check("hlt_start_ignored", ph(), 16'd7);
    check("hlt_strobes", stb(), 16'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hlt_rst_phase", ph(), 16'd0);
    check("hlt_rst_pc", bus.pc, 16'h0000);
    check("hlt_rst_flags", flg(), 16'h0000);
    check("hlt_rst_halt", hb(), 16'b00);

    // start together with rst is dropped
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check("start_rst_phase", ph(), 16'd0);
    tick();
    check("start_rst_hold", ph(), 16'd0);

    // rst during WB of ADD
    bus.mem_rdata = 16'hC000;
    set_alu(16'h0000, 4'b1111, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("wbrst_wb_phase", ph(), 16'd5);
    check("wbrst_wb_strobes", stb(), 16'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wbrst_phase", ph(), 16'd0);
    check("wbrst_strobes", stb(), 16'b000);
    check("wbrst_flags", flg(), 16'h0000);
    check("wbrst_pc", bus.pc, 16'h0000);

    // alu_hlt on an ordinary ADD also halts without loading flags
    set_alu(16'h0000, 4'b1010, 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("alu_hlt_phase", ph(), 16'd7);
    check("alu_hlt_flags", flg(), 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
